// File: rtl/sprite_blit_sequencer.sv
// Sprite blit sequencer: walks a location table and, for each entry, streams every
// sprite pixel from the ROM bank to a plotter through a valid/ready handshake.
module sprite_blit_sequencer #(
   parameter int unsigned N_ENT  = 16,
   parameter int unsigned SPR_W  = 16,
   parameter int unsigned SPR_H  = 16,
   parameter int unsigned CH_W   = 2,
   parameter int unsigned COL_W  = 3,
   parameter int unsigned XW     = 8,
   parameter int unsigned YW     = 7,
   parameter int unsigned TRANSP = 0
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   skip_transp,
   output logic [$clog2(N_ENT)-1:0]               ent_addr,
   input  logic [XW-1:0]                          ent_x,
   input  logic [YW-1:0]                          ent_y,
   input  logic [CH_W-1:0]                        ent_ch,
   output logic [$clog2(SPR_H)+$clog2(SPR_W)-1:0] pix_addr,
   output logic [CH_W-1:0]                        pix_ch,
   input  logic [COL_W-1:0]                       pix_colour,
   output logic [XW-1:0]                          out_x,
   output logic [YW-1:0]                          out_y,
   output logic [COL_W-1:0]                       out_colour,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   busy,
   output logic                                   done
);

   localparam int unsigned EW = $clog2(N_ENT);
   localparam int unsigned RW = $clog2(SPR_H);
   localparam int unsigned CW = $clog2(SPR_W);

   typedef enum logic [2:0] {IDLE, ENT_REQ, ENT_CAP, PIX_REQ, PIX_CAP, EMIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     idx_q, idx_d;
   logic              skip_q, skip_d;
   logic [XW-1:0]     ent_x_q, ent_x_d;
   logic [YW-1:0]     ent_y_q, ent_y_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [EW-1:0]     ent_addr_q, ent_addr_d;
   logic [RW+CW-1:0]  pix_addr_q, pix_addr_d;
   logic [CH_W-1:0]   pix_ch_q, pix_ch_d;
   logic [XW-1:0]     out_x_q, out_x_d;
   logic [YW-1:0]     out_y_q, out_y_d;
   logic [COL_W-1:0]  out_colour_q, out_colour_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              adv;
   logic              last_col, last_row, last_ent;

   assign last_col = (col_q == CW'(SPR_W - 1));
   assign last_row = (row_q == RW'(SPR_H - 1));
   assign last_ent = (idx_q == EW'(N_ENT - 1));

   // Next-state and registered-output computation; addresses hold outside request states.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      skip_d       = skip_q;
      ent_x_d      = ent_x_q;
      ent_y_d      = ent_y_q;
      row_d        = row_q;
      col_d        = col_q;
      ent_addr_d   = ent_addr_q;
      pix_addr_d   = pix_addr_q;
      pix_ch_d     = pix_ch_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_colour_d = out_colour_q;
      out_valid_d  = out_valid_q;
      done_d       = 1'b0;
      adv          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = ENT_REQ;
               idx_d      = '0;
               ent_addr_d = '0;
               skip_d     = skip_transp;
            end
         end
         ENT_REQ: state_d = ENT_CAP;
         ENT_CAP: begin
            ent_x_d    = ent_x;
            ent_y_d    = ent_y;
            pix_ch_d   = ent_ch;
            row_d      = '0;
            col_d      = '0;
            pix_addr_d = '0;
            state_d    = PIX_REQ;
         end
         PIX_REQ: state_d = PIX_CAP;
         PIX_CAP: begin
            if (skip_q && (pix_colour == COL_W'(TRANSP))) begin
               adv = 1'b1;
            end else begin
               out_colour_d = pix_colour;
               out_x_d      = ent_x_q + XW'(col_q);
               out_y_d      = ent_y_q + YW'(row_q);
               out_valid_d  = 1'b1;
               state_d      = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               adv         = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Step to the next pixel, the next entry, or the end of the pass.
      if (adv) begin
         if (last_col && last_row) begin
            if (last_ent) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               idx_d      = idx_q + EW'(1);
               ent_addr_d = idx_q + EW'(1);
               state_d    = ENT_REQ;
            end
         end else begin
            col_d      = last_col ? '0 : col_q + CW'(1);
            row_d      = last_col ? row_q + RW'(1) : row_q;
            pix_addr_d = {row_d, col_d};
            state_d    = PIX_REQ;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         skip_q       <= 1'b0;
         ent_x_q      <= '0;
         ent_y_q      <= '0;
         row_q        <= '0;
         col_q        <= '0;
         ent_addr_q   <= '0;
         pix_addr_q   <= '0;
         pix_ch_q     <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_colour_q <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         skip_q       <= skip_d;
         ent_x_q      <= ent_x_d;
         ent_y_q      <= ent_y_d;
         row_q        <= row_d;
         col_q        <= col_d;
         ent_addr_q   <= ent_addr_d;
         pix_addr_q   <= pix_addr_d;
         pix_ch_q     <= pix_ch_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_colour_q <= out_colour_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ent_addr   = ent_addr_q;
   assign pix_addr   = pix_addr_q;
   assign pix_ch     = pix_ch_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign out_colour = out_colour_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sprite_blit_sequencer.sv
// Directed bench for sprite_blit_sequencer: registered table/ROM models, a plot
// scoreboard sampled on the falling edge, and per-pass checks from the main thread.
module tb_sprite_blit_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       skip_transp;
   logic [3:0] ent_addr;
   logic [7:0] ent_x;
   logic [6:0] ent_y;
   logic [1:0] ent_ch;
   logic [7:0] pix_addr;
   logic [1:0] pix_ch;
   logic [2:0] pix_colour;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;

   sprite_blit_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .skip_transp(skip_transp),
      .ent_addr(ent_addr), .ent_x(ent_x), .ent_y(ent_y), .ent_ch(ent_ch),
      .pix_addr(pix_addr), .pix_ch(pix_ch), .pix_colour(pix_colour),
      .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [7:0] tbl_x [16];
   logic [6:0] tbl_y [16];
   logic [1:0] tbl_ch[16];
   int rom_mode = 0;
   int m_skip   = 0;
   int pass_id  = 0;
   int stall_en = 0;
   int n_tests  = 0;
   int n_fail   = 0;

   // Mode 0: colour 4+ch everywhere; mode 1: transparent on even columns, ch+1 on odd.
   function automatic logic [2:0] rom_col(int mode, logic [1:0] ch, int col);
      if (mode == 0) return 3'(4 + int'(ch));
      return (col % 2 == 0) ? 3'd0 : 3'(int'(ch) + 1);
   endfunction

   always @(posedge clock) begin
      ent_x      <= tbl_x[ent_addr];
      ent_y      <= tbl_y[ent_addr];
      ent_ch     <= tbl_ch[ent_addr];
      pix_colour <= rom_col(rom_mode, pix_ch, int'(pix_addr[3:0]));
   end

   // Plotter: ready stays high except for one 7-cycle stall at entry 2 when enabled.
   initial begin
      int stalled;
      stalled   = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         if (stall_en == 0) stalled = 0;
         else if (stalled == 0 && out_valid && ent_addr == 4'd2) begin
            stalled   = 1;
            out_ready = 1'b0;
            repeat (7) begin @(posedge clock); #1; end
            out_ready = 1'b1;
         end
      end
   end

   int seen_pass = 0;
   int m_e, m_r, m_c, plots, ent0_plots, errs, zero_plots, done_cnt, done_wide;
   int busy_cyc, stall_cyc, hold_errs, first_seen, first_x, first_y, first_col, b_x, b_y;

   // Scoreboard: every accepted plot is compared with the next expected sprite pixel.
   initial begin
      int prev_stall, prev_done, h_x, h_y, h_c;
      prev_stall = 0; prev_done = 0; h_x = 0; h_y = 0; h_c = 0;
      m_e = 0; m_r = 0; m_c = 0; plots = 0; ent0_plots = 0; errs = 0; zero_plots = 0;
      done_cnt = 0; done_wide = 0; busy_cyc = 0; stall_cyc = 0; hold_errs = 0;
      first_seen = 0; first_x = -1; first_y = -1; first_col = -1; b_x = -1; b_y = -1;
      forever begin
         @(negedge clock);
         if (pass_id != seen_pass) begin
            seen_pass = pass_id;
            m_e = 0; m_r = 0; m_c = 0; plots = 0; ent0_plots = 0; errs = 0; zero_plots = 0;
            done_cnt = 0; done_wide = 0; busy_cyc = 0; stall_cyc = 0; hold_errs = 0;
            first_seen = 0; first_x = -1; first_y = -1; first_col = -1; b_x = -1; b_y = -1;
            prev_stall = 0; prev_done = 0;
         end
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (prev_done != 0) done_wide++;
         end
         prev_done = int'(done);
         if (out_valid) begin
            if (prev_stall != 0 && (int'(out_x) != h_x || int'(out_y) != h_y || int'(out_colour) != h_c))
               hold_errs++;
            if (!out_ready) begin
               stall_cyc++;
               prev_stall = 1;
               h_x = int'(out_x); h_y = int'(out_y); h_c = int'(out_colour);
            end else begin
               prev_stall = 0;
               while (m_skip != 0 && m_e < 16 && rom_col(rom_mode, tbl_ch[m_e], m_c) == 3'd0) begin
                  m_c++;
                  if (m_c == 16) begin m_c = 0; m_r++; end
                  if (m_r == 16) begin m_r = 0; m_e++; end
               end
               if (m_e >= 16) errs++;
               else begin
                  if (out_x != 8'(int'(tbl_x[m_e]) + m_c) || out_y != 7'(int'(tbl_y[m_e]) + m_r) ||
                      out_colour != rom_col(rom_mode, tbl_ch[m_e], m_c)) errs++;
                  if (m_e == 1 && m_r == 15 && m_c == 10) begin b_x = int'(out_x); b_y = int'(out_y); end
                  if (m_e == 0) ent0_plots++;
               end
               if (first_seen == 0) begin
                  first_seen = 1;
                  first_x = int'(out_x); first_y = int'(out_y); first_col = int'(out_colour);
               end
               if (out_colour == 3'd0) zero_plots++;
               plots++;
               m_c++;
               if (m_c == 16) begin m_c = 0; m_r++; end
               if (m_r == 16) begin m_r = 0; m_e++; end
            end
         end else prev_stall = 0;
      end
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic run_pass(input int mode, input int skip);
      rom_mode    = mode;
      m_skip      = skip;
      skip_transp = skip[0];
      pass_id++;
      pulse_start();
      skip_transp = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 25000 && done_cnt == 0; i++) begin @(posedge clock); #2; end
      repeat (3) begin @(posedge clock); #2; end
      check_eq({tag, "_done_cnt"}, done_cnt, 1);
      check_eq({tag, "_done_wide"}, done_wide, 0);
      check_eq({tag, "_busy_after"}, int'(busy), 0);
      check_eq({tag, "_plot_errs"}, errs, 0);
   endtask

   initial begin
      int found;
      for (int e = 0; e < 16; e++) begin
         tbl_x[e]  = 8'(16 * e);
         tbl_y[e]  = 7'(8 * e);
         tbl_ch[e] = 2'(e % 4);
      end
      tbl_x[0] = 8'd10;  tbl_y[0] = 7'd20;  tbl_ch[0] = 2'd1;
      tbl_x[1] = 8'd250; tbl_y[1] = 7'd120; tbl_ch[1] = 2'd2;
      reset = 1'b0; start = 1'b1; skip_transp = 1'b0;

      // Reset with start held: start must be ignored.
      repeat (3) begin @(posedge clock); #1; end
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_valid", int'(out_valid), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_ent_addr", int'(ent_addr), 0);
      check_eq("rst_pix_addr", int'(pix_addr), 0);
      reset = 1'b1; start = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      check_eq("idle_busy", int'(busy), 0);

      // A + B: solid sprites, ready tied high.
      run_pass(0, 0);
      wait_done("A");
      check_eq("A_first_x", first_x, 10);
      check_eq("A_first_y", first_y, 20);
      check_eq("A_first_col", first_col, 5);
      check_eq("A_ent0_plots", ent0_plots, 256);
      check_eq("A_plots", plots, 4096);
      check_eq("A_busy_cycles", busy_cyc, 12321);
      check_eq("B_wrap_x", b_x, 4);
      check_eq("B_wrap_y", b_y, 7);

      // C (skip on) + F: start pulsed mid-pass must change nothing.
      run_pass(1, 1);
      repeat (500) @(posedge clock);
      #1 pulse_start();
      wait_done("C1");
      check_eq("C1_plots", plots, 2048);
      check_eq("C1_ent0_plots", ent0_plots, 128);
      check_eq("C1_zero_plots", zero_plots, 0);
      check_eq("C1_busy_cycles", busy_cyc, 10273);
      repeat (40) @(posedge clock);
      #2 check_eq("F_done_cnt", done_cnt, 1);
      check_eq("F_busy", int'(busy), 0);

      // C (skip off) + D: one 7-cycle stall at entry 2.
      stall_en = 1;
      run_pass(1, 0);
      wait_done("C2");
      stall_en = 0;
      check_eq("C2_plots", plots, 4096);
      check_eq("C2_ent0_plots", ent0_plots, 256);
      check_eq("C2_zero_plots", zero_plots, 2048);
      check_eq("D_stall_cycles", stall_cyc, 7);
      check_eq("D_hold_errs", hold_errs, 0);
      check_eq("D_busy_cycles", busy_cyc, 12328);

      // E: reset mid-EMIT at entry 5, with start asserted alongside reset.
      run_pass(0, 0);
      found = 0;
      for (int i = 0; i < 8000 && found == 0; i++) begin
         @(posedge clock); #1;
         if (ent_addr == 4'd5 && out_valid) found = 1;
      end
      check_eq("E_reached", found, 1);
      reset = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      check_eq("E_busy", int'(busy), 0);
      check_eq("E_valid", int'(out_valid), 0);
      check_eq("E_ent_addr", int'(ent_addr), 0);
      check_eq("E_pix_addr", int'(pix_addr), 0);
      check_eq("E_out_xyc", int'(out_x) + int'(out_y) + int'(out_colour), 0);
      reset = 1'b1; start = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      check_eq("E_idle", int'(busy), 0);
      run_pass(0, 0);
      wait_done("E2");
      check_eq("E2_first_x", first_x, 10);
      check_eq("E2_first_y", first_y, 20);
      check_eq("E2_plots", plots, 4096);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_blit_sequencer.md
SPRITE_BLIT_SEQUENCER -- requirements
Module: sprite_blit_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_ENT, 16, location-table entries per frame.
- SPR_W, 16, sprite width in pixels (power of 2).
- SPR_H, 16, sprite height in rows (power of 2).
- CH_W, 2, sprite-channel select width.
- COL_W, 3, colour width.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- TRANSP, 0, transparent colour code.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, clock.
- reset, in, 1, synchronous, active-low.
- start, in, 1, begin one frame pass.
- skip_transp, in, 1, suppress TRANSP pixels; sampled at start.
- ent_addr, out, clog2(N_ENT), location-table address.
- ent_x, in, XW, entry x; valid 1 cycle after ent_addr.
- ent_y, in, YW, entry y; same timing.
- ent_ch, in, CH_W, entry channel; same timing.
- pix_addr, out, clog2(SPR_H)+clog2(SPR_W), sprite ROM address {row,col}.
- pix_ch, out, CH_W, channel select to the sprite ROM bank.
- pix_colour, in, COL_W, ROM data; valid 1 cycle after pix_addr/pix_ch.
- out_x, out, XW, plot x.
- out_y, out, YW, plot y.
- out_colour, out, COL_W, plot colour.
- out_valid, out, 1, plot request.
- out_ready, in, 1, plotter accepts.
- busy, out, 1, pass in progress.
- done, out, 1, 1-cycle end-of-pass pulse.

Function
REQ-003 FSM states SHALL be IDLE, ENT_REQ, ENT_CAP, PIX_REQ, PIX_CAP, EMIT, DONE.
REQ-004 IDLE->ENT_REQ SHALL occur on start=1; entry index and skip mode latched; start ignored in any non-IDLE state.
REQ-005 ENT_REQ SHALL drive ent_addr=entry index; ENT_CAP SHALL register ent_x, ent_y, ent_ch; row=col=0.
REQ-006 PIX_REQ SHALL drive pix_addr={row,col}, pix_ch=latched channel; PIX_CAP SHALL register pix_colour.
REQ-007 PIX_CAP->EMIT SHALL occur unless skip mode=1 and colour==TRANSP, in which case advance directly (REQ-010).
REQ-008 EMIT SHALL assert out_valid with out_x=(ent_x+col) mod 2^XW, out_y=(ent_y+row) mod 2^YW, out_colour; wrap-around SHALL be silent truncation.
REQ-009 out_x/out_y/out_colour SHALL stay stable while out_valid=1 and out_ready=0; transfer occurs on the cycle both are 1.
REQ-010 Advance SHALL be: col+1; at col=SPR_W-1, col=0 and row+1; at row=SPR_H-1 and col=SPR_W-1, next entry via ENT_REQ; after entry N_ENT-1, go to DONE. Otherwise return to PIX_REQ.
REQ-011 DONE SHALL assert done for exactly 1 cycle, then go to IDLE; busy=1 in all states except IDLE.
REQ-012 Minimum cost SHALL be 3 cycles per emitted pixel with out_ready tied 1, 2 per skipped pixel, plus 2 per entry.
REQ-013 ent_addr and pix_addr SHALL hold their last value when not in a request state.

Reset
REQ-014 reset=0 on a rising clock SHALL force IDLE, out_valid=0, done=0, busy=0, indices, row, col and all address/coordinate/colour outputs =0, from any state including mid-EMIT.
REQ-015 start sampled in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-016 Scenario A: default params; entry 0 = (10,20,ch1); ROM all colour 5; out_ready=1 -> first plot (10,20,5), 256 plots per entry, 4096 total, done once.
REQ-017 Scenario B: ent_x=250, col=10 -> out_x=4 (wrap); ent_y=120, row=15 -> out_y=7.
REQ-018 Scenario C: skip_transp=1, ROM colour 0 on even cols -> 128 plots per entry, no plot with colour 0; skip_transp=0 -> 256 plots.
REQ-019 Scenario D: out_ready held 0 for 7 cycles during EMIT -> out_* stable, one transfer only.
REQ-020 Scenario E: reset=0 mid-pass at entry 5 -> next cycle IDLE, out_valid=0; new start restarts at entry 0.
REQ-021 Scenario F: start pulsed while busy -> ignored; pass count and done count unchanged.
